// File: rtl/cdb_arbiter_if.sv
// Bundles the two producer result ports, the RoB flush line and the CDB broadcast.
// The arbiter takes the slave side; producers, RoB and CDB consumers take the master side.
interface cdb_arbiter_if #(
    parameter int RoB_WIDTH = 8
);
    logic                 RSCA_en;
    logic [RoB_WIDTH-1:0] RSCA_RoB_index;
    logic [31:0]          RSCA_value;
    logic                 CARS_ready;

    logic                 LSBCA_en;
    logic [RoB_WIDTH-1:0] LSBCA_RoB_index;
    logic [31:0]          LSBCA_value;
    logic                 CALSB_ready;

    logic                 RoBCA_pre_judge;

    logic                 CACDB_en;
    logic [RoB_WIDTH-1:0] CACDB_RoB_index;
    logic [31:0]          CACDB_value;
    logic                 CACDB_src;

    modport master (
        output RSCA_en, RSCA_RoB_index, RSCA_value,
        output LSBCA_en, LSBCA_RoB_index, LSBCA_value,
        output RoBCA_pre_judge,
        input  CARS_ready, CALSB_ready,
        input  CACDB_en, CACDB_RoB_index, CACDB_value, CACDB_src
    );

    modport slave (
        input  RSCA_en, RSCA_RoB_index, RSCA_value,
        input  LSBCA_en, LSBCA_RoB_index, LSBCA_value,
        input  RoBCA_pre_judge,
        output CARS_ready, CALSB_ready,
        output CACDB_en, CACDB_RoB_index, CACDB_value, CACDB_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: two private FIFOs (ALU=0, LSB=1) drained one entry per cycle to a registered broadcast.
// Push at edge k reaches the CDB after edge k+1 at the earliest; ready drops only when a FIFO is full.
module cdb_arbiter #(
    parameter int RoB_WIDTH  = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int FIFO_PTR   = 1
) (
    input  logic             Sys_clk,
    input  logic             Sys_rst,
    input  logic             Sys_rdy,
    cdb_arbiter_if.slave     bus
);
    typedef struct packed {
        logic [RoB_WIDTH-1:0] idx;
        logic [31:0]          val;
    } ent_t;

    localparam logic [FIFO_PTR:0] CNT_FULL = (FIFO_PTR + 1)'(FIFO_DEPTH);

    ent_t                mem_q  [2][FIFO_DEPTH];
    logic [FIFO_PTR-1:0] wptr_q [2];
    logic [FIFO_PTR-1:0] wptr_d [2];
    logic [FIFO_PTR-1:0] rptr_q [2];
    logic [FIFO_PTR-1:0] rptr_d [2];
    logic [FIFO_PTR:0]   cnt_q  [2];
    logic [FIFO_PTR:0]   cnt_d  [2];
    logic                last_grant_q, last_grant_d;
    logic                cdb_en_q, cdb_en_d;
    ent_t                cdb_q, cdb_d;
    logic                cdb_src_q, cdb_src_d;

    ent_t                din    [2];
    logic [1:0]          rdy;
    logic [1:0]          nempty;
    logic [1:0]          push;
    logic [1:0]          pop;
    logic                gnt_lsb;
    logic                active;

    assign din[0] = {bus.RSCA_RoB_index, bus.RSCA_value};
    assign din[1] = {bus.LSBCA_RoB_index, bus.LSBCA_value};
    assign active = Sys_rst && bus.RoBCA_pre_judge && Sys_rdy;

    always_comb begin
        rdy          = '0;
        nempty       = '0;
        pop          = '0;
        gnt_lsb      = 1'b0;
        cdb_en_d     = 1'b0;
        cdb_d        = cdb_q;
        cdb_src_d    = cdb_src_q;
        last_grant_d = last_grant_q;
        for (int s = 0; s < 2; s++) begin
            rdy[s]    = (cnt_q[s] != CNT_FULL);
            nempty[s] = (cnt_q[s] != '0);
        end
        push = {bus.LSBCA_en, bus.RSCA_en} & rdy;

        // On a tie the side that did not win last time gets the bus.
        if (nempty[0] && (!nempty[1] || last_grant_q)) begin
            pop[0] = 1'b1;
        end else if (nempty[1]) begin
            pop[1]  = 1'b1;
            gnt_lsb = 1'b1;
        end
        if (|pop) begin
            cdb_en_d     = 1'b1;
            cdb_d        = mem_q[gnt_lsb][rptr_q[gnt_lsb]];
            cdb_src_d    = gnt_lsb;
            last_grant_d = gnt_lsb;
        end

        for (int s = 0; s < 2; s++) begin
            wptr_d[s] = wptr_q[s] + FIFO_PTR'(push[s]);
            rptr_d[s] = rptr_q[s] + FIFO_PTR'(pop[s]);
            cnt_d[s]  = cnt_q[s] + (FIFO_PTR + 1)'(push[s]) - (FIFO_PTR + 1)'(pop[s]);
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (!Sys_rst || !bus.RoBCA_pre_judge) begin
            for (int s = 0; s < 2; s++) begin
                cnt_q[s]  <= '0;
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
            end
            cdb_en_q  <= 1'b0;
            cdb_q     <= '0;
            cdb_src_q <= 1'b0;
            // A flush keeps the round-robin history; only reset restarts it.
            if (!Sys_rst) begin
                last_grant_q <= 1'b1;
            end
        end else if (Sys_rdy) begin
            for (int s = 0; s < 2; s++) begin
                cnt_q[s]  <= cnt_d[s];
                wptr_q[s] <= wptr_d[s];
                rptr_q[s] <= rptr_d[s];
            end
            cdb_en_q     <= cdb_en_d;
            cdb_q        <= cdb_d;
            cdb_src_q    <= cdb_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (active) begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    mem_q[s][wptr_q[s]] <= din[s];
                end
            end
        end
    end

    assign bus.CARS_ready      = rdy[0];
    assign bus.CALSB_ready     = rdy[1];
    assign bus.CACDB_en        = cdb_en_q;
    assign bus.CACDB_RoB_index = cdb_q.idx;
    assign bus.CACDB_value     = cdb_q.val;
    assign bus.CACDB_src       = cdb_src_q;
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between two result producers: the RS/ALU path and the LSB path.
- Each producer writes into a private 2-entry FIFO. A round-robin arbiter drains one entry per cycle onto a registered CDB broadcast.
- The broadcast is consumed by the RoB, RS, LSB and the Dispatcher's operand-forwarding logic.
- A mispredict flush discards everything that is queued or in flight.

Parameters:
- RoB_WIDTH, 8, width of a RoB index
- FIFO_DEPTH, 2, entries per requester FIFO; must be a power of two, minimum 2
- FIFO_PTR, 1, log2(FIFO_DEPTH)

Ports:
- Sys_clk  in  1  system clock; all state updates on posedge
- Sys_rst  in  1  synchronous reset, active-low (0 = reset)
- Sys_rdy  in  1  global enable; 0 freezes all state
- RSCA_en  in  1  ALU result valid
- RSCA_RoB_index  in  RoB_WIDTH  RoB entry of the ALU result
- RSCA_value  in  32  ALU result value
- CARS_ready  out  1  ALU FIFO can accept
- LSBCA_en  in  1  load/store result valid
- LSBCA_RoB_index  in  RoB_WIDTH  RoB entry of the LSB result
- LSBCA_value  in  32  LSB result value
- CALSB_ready  out  1  LSB FIFO can accept
- RoBCA_pre_judge  in  1  0 = mispredict, flush
- CACDB_en  out  1  broadcast valid this cycle
- CACDB_RoB_index  out  RoB_WIDTH  broadcast RoB index
- CACDB_value  out  32  broadcast value
- CACDB_src  out  1  0 = RS/ALU, 1 = LSB

Behaviour:
- Reset (Sys_rst==0 at posedge):
  - Both FIFOs empty; counts and pointers = 0.
  - CACDB_en=0, CACDB_RoB_index=0, CACDB_value=0, CACDB_src=0.
  - last_grant=1, so the ALU wins the first tie.
  - Reset has priority over flush and over Sys_rdy.
- Flush (RoBCA_pre_judge==0 at posedge, not in reset):
  - Same clearing as reset, except last_grant is kept.
  - Inputs presented in the flush cycle are dropped.
  - CACDB_en=0 on the following cycle.
- Sys_rdy==0 (not in reset or flush):
  - All registers hold, including CACDB_* outputs.
  - Pushes are ignored even if ready is high.
- Ready:
  - CARS_ready = (alu_count != FIFO_DEPTH); CALSB_ready likewise. Both are combinational from registered counts only, with no dependency on same-cycle pops.
  - Producers hold en/data until they sample ready=1.
- Push: an en&&ready&&Sys_rdy posedge writes at the write pointer, which wraps modulo FIFO_DEPTH. en while not ready is an input-protocol violation; the value is dropped and must be flagged by the bench.
- Arbitration (evaluated each posedge on pre-edge FIFO state):
  - Only ALU non-empty: grant ALU.
  - Only LSB non-empty: grant LSB.
  - Both non-empty: grant the side != last_grant, then update last_grant.
  - Neither non-empty: CACDB_en<=0; last_grant unchanged; data outputs hold their last values.
- Grant: pop the FIFO head and register it to CACDB_* with CACDB_en<=1. Exactly one broadcast per cycle.
- Latency:
  - A push at edge k is visible on the CDB after edge k+1 at the earliest.
  - No combinational bypass from input to CDB.
- Simultaneous push and pop on one FIFO in the same edge: count unchanged, both pointers advance. This is legal at any count < FIFO_DEPTH. When full, ready=0 so no push occurs.
- Ordering: per-source FIFO order is preserved. Cross-source order is defined only by the round-robin rule.
- Throughput: with both sources saturated, broadcasts alternate ALU, LSB, ALU, ... Each source gets 50%, and neither starves for more than one cycle.

Test Plan:
- Reset: Sys_rst=0 for 2 cycles with RSCA_en=1 → CACDB_en=0, CARS_ready=1, CALSB_ready=1, no broadcast after release.
- Single ALU push: idx=0x05, value=0xDEADBEEF at edge k → CACDB_en=1, idx=0x05, value=0xDEADBEEF, src=0 after edge k+1; CACDB_en=0 after k+2.
- Simultaneous push: ALU (idx 1, val 0x11) and LSB (idx 2, val 0x22) at the same edge after reset → ALU broadcast first, LSB next cycle, then CACDB_en=0.
- Saturation: RSCA_en and LSBCA_en held high for 8 cycles with incrementing idx → ready drops to 0 when a FIFO holds 2; broadcasts strictly alternate src 0,1,0,1; per-source idx sequence is monotonic with none lost.
- Flush: 2 ALU and 1 LSB entries queued, RoBCA_pre_judge=0 for 1 cycle → CACDB_en=0 next cycle; both ready=1; no stale idx is ever broadcast afterwards.
- Freeze: Sys_rdy=0 for 3 cycles with a broadcast of idx 7 on the bus and 1 entry queued → outputs hold idx 7 with CACDB_en=1 throughout; the queued entry is broadcast on the first edge after Sys_rdy=1.
